// File: rtl/mul_wb_sequencer.sv
// Write-back sequencer for the 64-bit Booth product: captures it on issue and
// retires it as two register-file writes (LO then HI), stalling the core until done.
module mul_wb_sequencer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2*DATA_W-1:0]   product,
    input  logic [ADDR_W-1:0]     rd_lo,
    input  logic [ADDR_W-1:0]     rd_hi,
    input  logic                  rf_busy,
    output logic                  rf_we,
    output logic [ADDR_W-1:0]     rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic                  stall,
    output logic                  done,
    output logic                  ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [2*DATA_W-1:0]   prod_q;
    logic [ADDR_W-1:0]     rdlo_q;
    logic [ADDR_W-1:0]     rdhi_q;
    logic                  ovf_q;
    logic                  capture;
    logic                  ovf_d;

    assign capture = (state_q == IDLE) && start;
    // Product fits in DATA_W signed bits only if the upper half is pure sign extension.
    assign ovf_d   = (product[2*DATA_W-1:DATA_W] != {DATA_W{product[DATA_W-1]}});
    assign ovf     = ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            prod_q  <= '0;
            rdlo_q  <= '0;
            rdhi_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                prod_q <= product;
                rdlo_q <= rd_lo;
                rdhi_q <= rd_hi;
                ovf_q  <= ovf_d;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        stall    = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            IDLE: begin
                stall = start;
                if (start) state_d = WR_LO;
            end
            WR_LO: begin
                stall    = 1'b1;
                rf_waddr = rdlo_q;
                rf_wdata = prod_q[DATA_W-1:0];
                rf_we    = ~rf_busy & (rdlo_q != '0);
                if (!rf_busy) state_d = WR_HI;
            end
            WR_HI: begin
                rf_waddr = rdhi_q;
                rf_wdata = prod_q[2*DATA_W-1:DATA_W];
                rf_we    = ~rf_busy & (rdhi_q != '0);
                if (!rf_busy) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mul_wb_sequencer.sv
// Bench for mul_wb_sequencer: directed steps plus random traffic checked against
// a queue-of-pending-writes model of the write-back sequence.
module tb_mul_wb_sequencer;

    localparam int W = 32;
    localparam int A = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [2*W-1:0] product;
    logic [A-1:0]   rd_lo;
    logic [A-1:0]   rd_hi;
    logic           rf_busy;
    logic           rf_we;
    logic [A-1:0]   rf_waddr;
    logic [W-1:0]   rf_wdata;
    logic           stall;
    logic           done;
    logic           ovf;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [A-1:0] addr;
        logic [W-1:0] data;
        bit           last;
    } wr_t;

    wr_t          pending[$];
    logic         modelOvf;
    logic [W-1:0] rfShadow [32];

    mul_wb_sequencer #(.DATA_W(W), .ADDR_W(A)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .product  (product),
        .rd_lo    (rd_lo),
        .rd_hi    (rd_hi),
        .rf_busy  (rf_busy),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .stall    (stall),
        .done     (done),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Expected outputs follow directly from the head of the pending-write queue.
    task automatic checkOutput();
        logic         eWe, eStall, eDone;
        logic [A-1:0] eAddr;
        logic [W-1:0] eData;
        if (pending.size() != 0) begin
            eAddr  = pending[0].addr;
            eData  = pending[0].data;
            eWe    = !rf_busy && (pending[0].addr != 0);
            eDone  = pending[0].last && !rf_busy;
            eStall = !eDone;
        end else begin
            eAddr  = '0;
            eData  = '0;
            eWe    = 1'b0;
            eDone  = 1'b0;
            eStall = start;
        end
        checkVal("rf_we",    64'(rf_we),    64'(eWe));
        checkVal("rf_waddr", 64'(rf_waddr), 64'(eAddr));
        checkVal("rf_wdata", 64'(rf_wdata), 64'(eData));
        checkVal("stall",    64'(stall),    64'(eStall));
        checkVal("done",     64'(done),     64'(eDone));
        checkVal("ovf",      64'(ovf),      64'(modelOvf));
        if (rf_we === 1'b1) rfShadow[rf_waddr] = rf_wdata;
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic [2*W-1:0] p,
                                 input logic [A-1:0] lo, input logic [A-1:0] hi,
                                 input logic b);
        longint sp;
        @(negedge clk);
        rst = r; start = s; product = p; rd_lo = lo; rd_hi = hi; rf_busy = b;
        #1;
        checkOutput();
        @(posedge clk);
        if (r) begin
            pending.delete();
            modelOvf = 1'b0;
        end else if (pending.size() != 0) begin
            if (!b) void'(pending.pop_front());
        end else if (s) begin
            pending.push_back('{addr: lo, data: p[W-1:0],   last: 1'b0});
            pending.push_back('{addr: hi, data: p[2*W-1:W], last: 1'b1});
            sp = $signed(p);
            modelOvf = (sp > 64'sd2147483647) || (sp < -64'sd2147483648);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, '0, '0, 0);
    endtask

    initial begin
        logic [2*W-1:0] rp;
        modelOvf = 1'b0;
        for (int i = 0; i < 32; i++) rfShadow[i] = '0;
        rst = 1; start = 0; product = '0; rd_lo = '0; rd_hi = '0; rf_busy = 0;
        @(posedge clk);
        applyStimulus(1, 0, '0, '0, '0, 0);
        applyStimulus(0, 0, '0, '0, '0, 0);

        // -1 * 1, fits in 32 bits
        applyStimulus(0, 1, 64'hFFFFFFFF_FFFFFFFF, 5, 6, 0);
        idle(2);
        checkVal("r5_final", 64'(rfShadow[5]), 64'hFFFFFFFF);
        checkVal("r6_final", 64'(rfShadow[6]), 64'hFFFFFFFF);
        checkVal("ovf_neg1", 64'(ovf), 64'd0);

        // 0x10000 * 0x10000 overflows
        applyStimulus(0, 1, 64'h00000001_00000000, 7, 8, 0);
        idle(2);
        checkVal("r8_final", 64'(rfShadow[8]), 64'h1);
        checkVal("ovf_big",  64'(ovf), 64'd1);

        // Register file busy for three cycles after issue
        rfShadow[7] = 32'hDEAD;
        applyStimulus(0, 1, 64'h00000001_00000000, 7, 8, 0);
        applyStimulus(0, 0, '0, 0, 0, 1);
        applyStimulus(0, 0, '0, 0, 0, 1);
        applyStimulus(0, 0, '0, 0, 0, 1);
        applyStimulus(0, 0, '0, 0, 0, 0);
        applyStimulus(0, 0, '0, 0, 0, 0);
        checkVal("r7_busy", 64'(rfShadow[7]), 64'h0);

        // Zero LO destination suppresses the write only
        applyStimulus(0, 1, 64'h12345678_9ABCDEF0, 0, 9, 0);
        idle(2);
        checkVal("r9_final", 64'(rfShadow[9]), 64'h12345678);
        checkVal("r0_final", 64'(rfShadow[0]), 64'h0);

        // Second start during WR_LO is ignored; writes keep captured data
        applyStimulus(0, 1, 64'hAAAA0000_BBBB1111, 10, 11, 0);
        applyStimulus(0, 1, 64'h55555555_66666666, 12, 13, 1);
        applyStimulus(0, 1, 64'h55555555_66666666, 12, 13, 0);
        applyStimulus(0, 0, '0, 0, 0, 0);
        checkVal("r11_final", 64'(rfShadow[11]), 64'hAAAA0000);
        checkVal("r12_untouched", 64'(rfShadow[12]), 64'h0);

        // Reset mid-operation aborts with no further writes
        applyStimulus(0, 1, 64'h00000002_00000000, 14, 15, 0);
        applyStimulus(1, 0, '0, 0, 0, 0);
        idle(2);
        checkVal("r15_abort", 64'(rfShadow[15]), 64'h0);
        checkVal("ovf_reset", 64'(ovf), 64'd0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(2, 0))
                0: rp = {$urandom(), $urandom()};
                1: rp = 64'($signed($urandom()));
                default: rp = {{31{1'b0}}, 1'b1, $urandom()};
            endcase
            applyStimulus(($urandom_range(60, 0) == 0),
                          $urandom_range(1, 0),
                          rp,
                          ($urandom_range(5, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 1)),
                          ($urandom_range(5, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 1)),
                          ($urandom_range(3, 0) == 0));
        end
        idle(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout");
        $fatal(1, "[TB] timeout");
    end

endmodule
